hilo_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It iteratively executes MULT, MULTU, DIV and DIVU, and it services the MTHI and MTLO writes. It sits beside the single-cycle ALU in the execute stage. The pipeline stalls any HI/LO reader while `busy` is high.

---
 rtl/hilo_muldiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair, plus MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete in one cycle and leave HI/LO unchanged.
module hilo_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_FIX  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              psign_q, psign_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [XLEN:0]     sum_s;
`ifdef MULDIV_DIV_EN
    logic              rsign_q, rsign_d;
    logic              dz_q, dz_d;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     diff_s;
`endif

    // Two's-complement magnitude for signed operands, raw value for unsigned ones.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        if (sgn && v[XLEN-1]) begin
            mag = -v;
        end else begin
            mag = v;
        end
    endfunction

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        psign_d  = psign_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        // Right-shifting shift-add: the partial product's upper half absorbs the multiplicand.
        sum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
`ifdef MULDIV_DIV_EN
        rsign_d  = rsign_q;
        dz_d     = dz_q;
        rem_sh_s = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, b_q};
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'b100: hi_d = a;
                        3'b101: lo_d = a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            a_d      = mag(a, op[0]);
                            b_d      = mag(b, op[0]);
                            psign_d  = op[0] & (a[XLEN-1] ^ b[XLEN-1]);
                            is_div_d = op[1];
                            acc_d    = {(2*XLEN){1'b0}};
                            cnt_d    = {CW{1'b0}};
`ifdef MULDIV_DIV_EN
                            rsign_d  = op[0] & a[XLEN-1];
                            dz_d     = (b == {XLEN{1'b0}});
                            state_d  = op[1] ? ST_DIV : ST_MUL;
`else
                            state_d  = op[1] ? ST_FIX : ST_MUL;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = {sum_s, acc_q[XLEN-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_MUL;
                end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                // Upper half holds the partial remainder, lower half collects quotient bits.
                if (!diff_s[XLEN]) begin
                    acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                a_d   = a_q << 1;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
`endif
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                    // A zero divisor yields an all-ones quotient that must not be negated.
                    hi_d = rsign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                    lo_d = (psign_q && !dz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
`else
                    hi_d = hi_q;
                    lo_d = lo_q;
`endif
                end else begin
                    {hi_d, lo_d} = psign_q ? -acc_q : acc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            psign_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            psign_q  <= psign_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef MULDIV_DIV_EN
            rsign_q  <= rsign_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: cycle-level arithmetic model plus directed literal checks.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_hilo_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    logic [31:0] lit_hi = 32'd0, lit_lo = 32'd0;

    hilo_muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Expected {write, hi, lo} of an arithmetic op, straight from the arithmetic rules.
    function automatic logic [64:0] model_fn(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        if (o == 3'd0) begin
            p = {32'd0, x} * {32'd0, y};
            return {1'b1, p};
        end else if (o == 3'd1) begin
            p = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
            return {1'b1, p};
        end
`ifdef MULDIV_DIV_EN
        else if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
        else if (o == 3'd2) return {1'b1, x % y, x / y};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b1, 32'd0, 32'h80000000};
        else return {1'b1, 32'(sx % sy), 32'(sx / sy)};
`else
        else return {1'b0, 64'd0};
`endif
    endfunction

    function automatic int lat_fn(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
        return 33;
`else
        return o[1] ? 1 : 33;
`endif
    endfunction

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_done, m_wr;
    int          m_rem;

    // Reference model: remaining-busy-cycle counter and pending result.
    always @(posedge clk) begin
        if (reset) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0; m_rem <= 0; m_wr <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1 && m_wr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (op == 3'd4) m_hi <= a;
                else if (op == 3'd5) m_lo <= a;
                else if (op < 3'd4) begin
                    {m_wr, m_phi, m_plo} <= model_fn(op, a, b);
                    m_rem <= lat_fn(op);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({busy, done, hi, lo} !== {(m_rem != 0), m_done, m_hi, m_lo}) begin
                errors++;
                $display("FAIL cycle t=%0t busy/done/hi/lo got %b %b %h %h want %b %b %h %h",
                         $time, busy, done, hi, lo, (m_rem != 0), m_done, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input bit noise, output int bc, output bit gd);
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 40 && !gd; i++) begin
            if (done) begin
                gd = 1'b1;
            end else begin
                if (busy) bc++;
                if (noise) begin
                    start = ($urandom_range(0, 2) == 0);
                    op = 3'($urandom_range(0, 7));
                    a = $urandom;
                    b = $urandom;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit now, input bit noise, output int bc, output bit gd);
        if (!now) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(noise, bc, gd);
    endtask

    task automatic run_lit(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el, input bit now);
        int bc, eb;
        bit gd;
        logic [31:0] h2, l2;
        h2 = eh; l2 = el; eb = 33;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            h2 = lit_hi; l2 = lit_lo; eb = 1;
        end
`endif
        do_op(o, x, y, now, 1'b0, bc, gd);
        chk({nm, " done"}, 64'(gd), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(h2));
        chk({nm, " lo"}, 64'(lo), 64'(l2));
        chk({nm, " busy_cycles"}, 64'(bc), 64'(eb));
        lit_hi = h2;
        lit_lo = l2;
    endtask

    initial begin
        int bc;
        bit gd, saw_done;
        logic [31:0] corner [6];
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF; corner[5] = 32'h2;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_state", {30'd0, busy, done, hi}, 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_lit("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_lit("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
        run_lit("mult_min_sq", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        run_lit("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_lit("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1);
        run_lit("divu_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_lit("divu_by0", 3'd2, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b0);
        run_lit("div_by0", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hAAAA;
        @(negedge clk);
        chk("mthi_zero_stall", 64'(hi), 64'h0000AAAA);
        op = 3'd5; a = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h0000AAAA);
        chk("mtlo_lo", 64'(lo), 64'h00005555);
        chk("mt_busy", {62'd0, busy, done}, 64'd0);

        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, bc, gd);
        chk("mtlo_mid_done", 64'(gd), 64'd1);
        chk("mtlo_mid_lo", 64'(lo), 64'd63);

        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'h12345; b = 32'hFFFF0001;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {30'd0, busy, done, hi}, 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        lit_hi = 32'd0; lit_lo = 32'd0;
        run_lit("multu_3x4", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if (ro < 3'd4) begin
                do_op(ro, ra, rb, $urandom_range(0, 1) == 1, 1'b1, bc, gd);
                chk("rand_done", 64'(gd), 64'd1);
            end else begin
                @(negedge clk);
                start = 1'b1; op = ro; a = ra; b = rb;
                @(negedge clk);
                start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
